// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, result held with its ROB tag until the CDB arbiter takes it.
module ex_muldiv #(
   parameter int XLEN      = 32,
   parameter int ROB_IDX_W = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 flush_in,
   input  logic                 issue_valid_in,
   output logic                 issue_ready_out,
   input  logic [2:0]           op_in,
   input  logic [XLEN-1:0]      rs1_in,
   input  logic [XLEN-1:0]      rs2_in,
   input  logic [ROB_IDX_W-1:0] rob_pos_in,
   output logic                 out_valid_out,
   input  logic                 out_ready_in,
   output logic [XLEN-1:0]      res_out,
   output logic [ROB_IDX_W-1:0] rob_pos_out
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                 state_r;
   logic [CW-1:0]          cnt_r;
   logic [2:0]             op_r;
   logic                   neg_a_r, neg_b_r;
   logic [2*XLEN-1:0]      acc_r;
   logic [XLEN-1:0]        opr_r;
   logic [ROB_IDX_W-1:0]   tag_r;
   logic                   out_valid_r;
   logic [XLEN-1:0]        res_r;
   logic [ROB_IDX_W-1:0]   rob_r;

   logic                   a_signed_s, b_signed_s, neg_a_s, neg_b_s;
   logic [XLEN-1:0]        mag_a_s, mag_b_s;
   logic                   div_zero_s, ovf_s, special_s, accept_s;
   logic [XLEN-1:0]        special_res_s;
   logic [XLEN:0]          mul_sum_s, div_tmp_s;
   logic [XLEN-1:0]        div_diff_s;
   logic [2*XLEN-1:0]      step_s, prod_s;
   logic [XLEN-1:0]        quo_s, rem_s, fix_res_s;

   assign issue_ready_out = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready_in);
   assign accept_s        = rdy_in & issue_valid_in & issue_ready_out & ~flush_in;
   assign out_valid_out   = out_valid_r;
   assign res_out         = res_r;
   assign rob_pos_out     = rob_r;

   // Operand signedness per funct3
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (op_in)
         3'd1, 3'd4, 3'd6: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
         end
         3'd2:    a_signed_s = 1'b1;
         default: a_signed_s = 1'b0;
      endcase
   end

   assign neg_a_s    = a_signed_s & rs1_in[XLEN-1];
   assign neg_b_s    = b_signed_s & rs2_in[XLEN-1];
   assign mag_a_s    = neg_a_s ? -rs1_in : rs1_in;
   assign mag_b_s    = neg_b_s ? -rs2_in : rs2_in;
   assign div_zero_s = op_in[2] & (rs2_in == {XLEN{1'b0}});
   assign ovf_s      = op_in[2] & ~op_in[0] & (rs1_in == INT_MIN) & (rs2_in == {XLEN{1'b1}});
   assign special_s  = div_zero_s | ovf_s;

   // Results of the cases that skip iteration (op_in[1] selects remainder)
   always_comb begin
      special_res_s = {XLEN{1'b0}};
      if (div_zero_s) begin
         special_res_s = op_in[1] ? rs1_in : {XLEN{1'b1}};
      end else if (ovf_s) begin
         special_res_s = op_in[1] ? {XLEN{1'b0}} : rs1_in;
      end else begin
         special_res_s = {XLEN{1'b0}};
      end
   end

   // One iteration: acc_r holds {hi, lo}; lo is multiplier or dividend/quotient
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opr_r} : {(XLEN+1){1'b0}});
      div_tmp_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      div_diff_s = div_tmp_s[XLEN-1:0] - opr_r;
      step_s     = {2*XLEN{1'b0}};
      if (op_r[2]) begin
         if (div_tmp_s >= {1'b0, opr_r}) begin
            step_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
         end else begin
            step_s = {div_tmp_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
         end
      end else begin
         step_s = {mul_sum_s, acc_r[XLEN-1:1]};
      end
   end

   // Sign correction and half/quotient/remainder select
   always_comb begin
      prod_s    = (neg_a_r ^ neg_b_r) ? -acc_r : acc_r;
      quo_s     = (neg_a_r ^ neg_b_r) ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      rem_s     = neg_a_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      fix_res_s = {XLEN{1'b0}};
      case (op_r)
         3'd0:             fix_res_s = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fix_res_s = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fix_res_s = quo_s;
         default:          fix_res_s = rem_s;
      endcase
   end

   // Control FSM, iterative datapath and registered result
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CW{1'b0}};
         op_r        <= 3'd0;
         neg_a_r     <= 1'b0;
         neg_b_r     <= 1'b0;
         acc_r       <= {2*XLEN{1'b0}};
         opr_r       <= {XLEN{1'b0}};
         tag_r       <= {ROB_IDX_W{1'b0}};
         out_valid_r <= 1'b0;
         res_r       <= {XLEN{1'b0}};
         rob_r       <= {ROB_IDX_W{1'b0}};
      end else if (rdy_in) begin
         if (flush_in) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
         end else if (accept_s) begin
            op_r    <= op_in;
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
            tag_r   <= rob_pos_in;
            cnt_r   <= CW'(XLEN);
            acc_r   <= {{XLEN{1'b0}}, (op_in[2] ? mag_a_s : mag_b_s)};
            opr_r   <= op_in[2] ? mag_b_s : mag_a_s;
            if (special_s) begin
               state_r     <= ST_DONE;
               out_valid_r <= 1'b1;
               res_r       <= special_res_s;
               rob_r       <= rob_pos_in;
            end else begin
               state_r     <= ST_BUSY;
               out_valid_r <= 1'b0;
            end
         end else begin
            case (state_r)
               ST_BUSY: begin
                  acc_r <= step_s;
                  cnt_r <= cnt_r - CW'(1);
                  if (cnt_r == CW'(1)) begin
                     state_r <= ST_FIX;
                  end
               end
               ST_FIX: begin
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b1;
                  res_r       <= fix_res_s;
                  rob_r       <= tag_r;
               end
               ST_DONE: begin
                  if (out_ready_in) begin
                     state_r     <= ST_IDLE;
                     out_valid_r <= 1'b0;
                  end
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: a driver pushes model results on accept, a monitor
// pops and compares on every result transfer; directed corner cases plus random traffic.
module tb_ex_muldiv;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush_in, issue_valid_in, issue_ready_out;
   logic [2:0]  op_in;
   logic [31:0] rs1_in, rs2_in, res_out;
   logic [3:0]  rob_pos_in, rob_pos_out;
   logic        out_valid_out, out_ready_in;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   bit rnd_en = 1'b0;

   ex_muldiv #(.XLEN(32), .ROB_IDX_W(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
      .op_in(op_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rob_pos_in(rob_pos_in),
      .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
      .res_out(res_out), .rob_pos_out(rob_pos_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference: RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      int              ia = a;
      int              ib = b;
      logic [63:0]     p;
      logic [31:0]     r;
      case (op)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 32'd0) ? a :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Called right after a posedge; returns #1 after the accepting edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      int   n = 0;
      exp_t e;
      op_in = op; rs1_in = a; rs2_in = b; rob_pos_in = tag; issue_valid_in = 1'b1;
      @(negedge clk_in);
      while (!(issue_ready_out && rdy_in && !flush_in) && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 1000) timeout("issue_wait");
      e.res = model(op, a, b);
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk_in);
      #1 issue_valid_in = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk_in);
         #1 n++;
      end
      if (n >= 2000) timeout("drain_wait");
   endtask

   // Monitor: a transfer happens on the next edge when these hold
   always @(negedge clk_in) begin
      if (rst_in && out_valid_out && out_ready_in && rdy_in && !flush_in) begin
         if (exp_q.size() == 0) begin
            timeout("unexpected_result");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_res", res_out, e.res);
            check("sb_tag", {28'd0, rob_pos_out}, {28'd0, e.tag});
         end
      end
   end

   // Random stall and backpressure during the random phase
   always @(posedge clk_in) begin
      if (rnd_en) begin
         #1;
         rdy_in       = ($urandom_range(0, 3) != 0);
         out_ready_in = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      int k;
      bit seen;
      logic [31:0] pick[6];
      logic [31:0] hold_res;
      rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; issue_valid_in = 1'b0;
      op_in = 3'd0; rs1_in = 32'd0; rs2_in = 32'd0; rob_pos_in = 4'd0; out_ready_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_valid", {31'd0, out_valid_out}, 32'd0);
      check("rst_res", res_out, 32'd0);
      check("rst_tag", {28'd0, rob_pos_out}, 32'd0);
      check("rst_ready", {31'd0, issue_ready_out}, 32'd1);
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;

      // MUL latency and backpressure hold
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 4'd3);
      k = 0;
      while (!out_valid_out && k < 80) begin @(posedge clk_in); #1 k++; end
      check("mul_latency", k, 32'd33);
      hold_res = res_out;
      check("mul_res_direct", res_out, 32'hFFFF_FFEB);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_in); #1;
         check("bp_res", res_out, hold_res);
         check("bp_tag", {28'd0, rob_pos_out}, 32'd3);
         check("bp_ready", {31'd0, issue_ready_out}, 32'd0);
      end

      // Take result and accept a new op on the same edge
      out_ready_in = 1'b1;
      issue(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd5);
      check("b2b_valid_low", {31'd0, out_valid_out}, 32'd0);
      check("b2b_q_depth", exp_q.size(), 32'd1);
      wait_empty();

      // Directed list, issued back to back
      issue(3'd3, 32'h8000_0000, 32'h8000_0000, 4'd1);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2, 4'd2);
      issue(3'd5, 32'd7, 32'd0, 4'd4);
      issue(3'd7, 32'd7, 32'd0, 4'd6);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd9);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 4'd10);
      issue(3'd5, 32'd100, 32'd7, 4'd11);
      issue(3'd7, 32'd100, 32'd7, 4'd12);
      wait_empty();

      // Special case completes on the accepting edge
      out_ready_in = 1'b0;
      issue(3'd4, 32'd7, 32'd0, 4'd13);
      check("special_latency", {31'd0, out_valid_out}, 32'd1);
      check("special_res", res_out, 32'hFFFF_FFFF);
      out_ready_in = 1'b1;
      wait_empty();

      // Flush at edge 10 of a MUL, with a competing issue on the flush edge
      issue(3'd0, 32'd123, 32'd456, 4'd14);
      repeat (9) @(posedge clk_in);
      #1 flush_in = 1'b1;
      op_in = 3'd5; rs1_in = 32'd9; rs2_in = 32'd0; issue_valid_in = 1'b1;
      @(posedge clk_in);
      #1 flush_in = 1'b0; issue_valid_in = 1'b0;
      check("flush_ready", {31'd0, issue_ready_out}, 32'd1);
      check("flush_valid", {31'd0, out_valid_out}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 35; i++) begin @(posedge clk_in); #1 seen |= out_valid_out; end
      check("flush_no_valid", {31'd0, seen}, 32'd0);
      void'(exp_q.pop_back());
      issue(3'd0, 32'd11, 32'd13, 4'd15);
      wait_empty();

      // rdy_in low for 4 cycles mid-BUSY adds 4 cycles
      out_ready_in = 1'b0;
      issue(3'd5, 32'd100, 32'd7, 4'd9);
      k = 0;
      while (!out_valid_out && k < 80) begin
         @(posedge clk_in); #1 k++;
         if (k == 5) rdy_in = 1'b0;
         if (k == 9) rdy_in = 1'b1;
      end
      check("stall_latency", k, 32'd37);
      out_ready_in = 1'b1;
      wait_empty();

      // Random traffic with random stalls and backpressure
      pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
      pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF; pick[5] = 32'd0;
      rnd_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a, b;
         a = $urandom(); b = $urandom();
         if ($urandom_range(0, 3) == 0) a = pick[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0) b = pick[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         issue(3'($urandom_range(0, 7)), a, b, 4'($urandom_range(0, 15)));
      end
      wait_empty();
      rnd_en = 1'b0;
      @(posedge clk_in);
      #2 rdy_in = 1'b1; out_ready_in = 1'b0;

      // Async reset while a result is held
      issue(3'd6, 32'd5, 32'd0, 4'd2);
      #3 rst_in = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_valid_out}, 32'd0);
      check("async_rst_res", res_out, 32'd0);
      check("async_rst_ready", {31'd0, issue_ready_out}, 32'd1);
      void'(exp_q.pop_back());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multi-cycle execution unit for the RV32M multiply/divide instructions, parametrised in data width and ROB tag width. It sits beside the single-cycle ALU execute stage: it accepts one operation from the reservation station through a valid/ready handshake and computes it over multiple cycles. It then holds the result with its ROB tag until the common-data-bus arbiter takes it. A misprediction flush cancels any in-flight operation.

## Interface
- `XLEN`, 32: operand and result width (≥ 8, even).
- `ROB_IDX_W`, 4: ROB index width, equal to the codebase ROB index width.

- `clk_in`  in  1  single clock; all state updates on its rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global ready; low freezes all state (reset still acts).
- `flush_in`  in  1  misprediction clear, sampled only when `rdy_in` is high.
- `issue_valid_in`  in  1  RS offers an operation.
- `issue_ready_out`  out  1  unit accepts an operation this cycle.
- `op_in`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_in`, `rs2_in`  in  XLEN  operands.
- `rob_pos_in`  in  ROB_IDX_W  destination ROB entry.
- `out_valid_out`  out  1  result held and valid.
- `out_ready_in`  in  1  CDB arbiter takes the result this cycle.
- `res_out`  out  XLEN  result.
- `rob_pos_out`  out  ROB_IDX_W  ROB entry of `res_out`.

## Operation
- States:
  - IDLE: waiting for an operation.
  - BUSY: one iteration per cycle; a down-counter of width clog2(XLEN+1) runs from XLEN to 0.
  - FIX: sign correction and half select.
  - DONE: result held.
- Accept condition: an operation is accepted on an edge where `rdy_in & issue_valid_in & issue_ready_out & ~flush_in`. On that edge the unit latches `op_in`, both operand magnitudes, the sign flags and `rob_pos_in`.
- `issue_ready_out = (state==IDLE) | (state==DONE & out_ready_in)`. This allows back-to-back issue in the cycle the result is taken.
- Multiply:
  - Radix-2 shift-add on the magnitudes into a 2·XLEN product.
  - Signed treatment by op: MULH treats both operands as signed, MULHSU treats rs1 as signed and rs2 as unsigned, MULHU and MUL treat both as unsigned magnitude.
  - FIX negates the product when the operand signs differ.
  - MUL returns bits [XLEN-1:0]; the MULH variants return [2·XLEN-1:XLEN].
- Divide:
  - Restoring divide on the magnitudes, one quotient bit per cycle.
  - FIX negates the quotient when the signs differ (DIV) and gives the remainder the sign of the dividend (REM).
- Special cases are decided at accept and bypass BUSY; IDLE goes to DONE in one edge:
  - Divide by zero: quotient is all ones; remainder is rs1.
  - Signed overflow (DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = all ones): quotient is rs1; remainder is 0.
- Normal transitions: IDLE → BUSY on accept; BUSY → FIX on the edge where the counter reaches 0; FIX → DONE.
- DONE exits:
  - With `out_ready_in` and a new accept: → BUSY, or → DONE for a special case.
  - With `out_ready_in` and no accept: → IDLE.
  - Without `out_ready_in`: hold.
- Flush: `flush_in` on an edge (with `rdy_in` high) forces IDLE from any state. It clears `out_valid_out`, and any issue offered in the same cycle is ignored. An un-taken DONE result is discarded.
- `rdy_in` low: state, counter, datapath and outputs hold; handshakes do not complete.

## Timing
- Reset values: `out_valid_out`=0, `res_out`=0, `rob_pos_out`=0, state IDLE, so `issue_ready_out`=1.
- `res_out` and `rob_pos_out` are registered and stable throughout DONE.
- Normal latency: accept on edge 0 → XLEN iterations on edges 1..XLEN → FIX on edge XLEN+1 → `out_valid_out` high after edge XLEN+1. For XLEN=32 this is valid after edge 33.
- Special-case latency: `out_valid_out` high after edge 1.
- A result is transferred on an edge with `out_valid_out & out_ready_in & rdy_in`.
- Every `rdy_in`-low cycle extends latency by exactly one cycle.
- Reset asserted mid-operation returns the unit to its reset values immediately, without waiting for a clock edge.

## Test plan
- MUL 7 × 0xFFFFFFFD, tag 3, at edge 0 → `out_valid_out` rises after edge 33; `res_out`=0xFFFFFFEB, `rob_pos_out`=3.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU on the same operands → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 7 / 0 → 0xFFFFFFFF after edge 1. REMU 7 / 0 → 7. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Flush at edge 10 during a MUL → `out_valid_out` never rises; `issue_ready_out`=1 after edge 10. A new op issued at edge 11 completes normally.
- Backpressure and stalls:
  - Hold `out_ready_in` low for 5 cycles in DONE → `res_out` and `rob_pos_out` stay constant and `issue_ready_out`=0.
  - Raise `out_ready_in` together with a new issue → the result is taken and the new op is accepted on the same edge.
  - Hold `rdy_in` low for 4 cycles mid-BUSY → valid arrives 4 cycles late with the correct value.
